// File: rtl/mem_ctrl_bank.sv
// mem_ctrl_bank: single-clock dual-port memory bank with byte-lane writes and a 1- or 2-stage read pipeline.
// A post-reset clear engine zeroes one word per cycle. Optional macro MEM_BYPASS_EN forwards same-address writes to reads.
module mem_ctrl_bank #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                w_en,
   input  logic [ADDR_W-1:0]   w_adrs,
   input  logic [DATA_W/8-1:0] w_be,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                r_en,
   input  logic [ADDR_W-1:0]   r_adrs,
   output logic [DATA_W-1:0]   data_out,
   output logic                r_valid,
   output logic                busy,
   output logic                o_dbg_ready
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NB    = DATA_W/8;

   if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
      $error("mem_ctrl_bank: DATA_W must be a non-zero multiple of 8");
   end
   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("mem_ctrl_bank: RD_LAT must be 1 or 2");
   end

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_clr_ptr;
   logic                r_busy;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                r_s1_valid;
   logic [DATA_W-1:0]   r_s1_data;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;

   logic                w_wr_accept;
   logic                w_rd_accept;
   logic [DATA_W-1:0]   w_rd_word;

   assign w_wr_accept = (r_state == S_READY) && w_en;
   assign w_rd_accept = (r_state == S_READY) && r_en;

   // Clear engine: one zeroed word per cycle; leaving CLEAR is final until the next reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_CLEAR;
         r_clr_ptr <= '0;
         r_busy    <= 1'b1;
      end else if (r_state == S_CLEAR) begin
         r_clr_ptr <= r_clr_ptr + 1'b1;
         if (&r_clr_ptr) begin
            r_state <= S_READY;
            r_busy  <= 1'b0;
         end
      end
   end

   // Array is left untouched during reset; the clear pass that follows overwrites it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == S_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
         end else if (w_wr_accept) begin
            for (int b = 0; b < NB; b++) begin
               if (w_be[b]) begin
                  r_mem[w_adrs][8*b +: 8] <= data_in[8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      w_rd_word = r_mem[r_adrs];
`ifdef MEM_BYPASS_EN
      if (w_wr_accept && (w_adrs == r_adrs)) begin
         for (int b = 0; b < NB; b++) begin
            if (w_be[b]) begin
               w_rd_word[8*b +: 8] = data_in[8*b +: 8];
            end
         end
      end
`endif
   end

   // Read pipeline: the extra stage is only on the path when RD_LAT is 2.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_s1_valid <= w_rd_accept;
         if (w_rd_accept) begin
            r_s1_data <= w_rd_word;
         end
         if (RD_LAT == 1) begin
            r_out_valid <= w_rd_accept;
            if (w_rd_accept) begin
               r_out_data <= w_rd_word;
            end
         end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_out_data <= r_s1_data;
            end
         end
      end
   end

   assign data_out    = r_out_data;
   assign r_valid     = r_out_valid;
   assign busy        = r_busy;
   assign o_dbg_ready = (r_state == S_READY);

endmodule

// File: tb/tb_mem_ctrl_bank.sv
// tb_mem_ctrl_bank: drives one RD_LAT=1 and one RD_LAT=2 bank (16x32) with shared stimulus and
// scoreboards both against an array model; honours MEM_BYPASS_EN for same-address reads.
module tb_mem_ctrl_bank;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NB    = 4;
`ifdef MEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          w_en;
  logic [AW-1:0] w_adrs;
  logic [NB-1:0] w_be;
  logic [DW-1:0] data_in;
  logic          r_en;
  logic [AW-1:0] r_adrs;
  logic [DW-1:0] dout1, dout2;
  logic          rv1, rv2, busy1, busy2, dbg1, dbg2;

  mem_ctrl_bank #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .w_en(w_en), .w_adrs(w_adrs), .w_be(w_be), .data_in(data_in),
    .r_en(r_en), .r_adrs(r_adrs), .data_out(dout1), .r_valid(rv1), .busy(busy1), .o_dbg_ready(dbg1));

  mem_ctrl_bank #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .w_en(w_en), .w_adrs(w_adrs), .w_be(w_be), .data_in(data_in),
    .r_en(r_en), .r_adrs(r_adrs), .data_out(dout2), .r_valid(rv2), .busy(busy2), .o_dbg_ready(dbg2));

  int checks = 0;
  int errors = 0;

  // reference model: memory contents plus "ready after DEPTH clean cycles"
  logic [DW-1:0] m_mem [DEPTH];
  int            m_cnt = 0;
  bit            m_ready = 1'b0;
  int            cyc = 0;
  bit            started = 1'b0;
  int            rst_gen = 0;

  // scoreboard
  logic [DW-1:0] exp_q1[$], exp_q2[$];
  int            due_q1[$], due_q2[$];
  logic [DW-1:0] got1 = '0, got2 = '0;

  always @(posedge clk) begin
    logic [DW-1:0] e;
    cyc++;
    if (reset) begin
      started = 1'b1;
      m_cnt   = 0;
      m_ready = 1'b0;
      rst_gen++;
    end else if (!m_ready) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1'b1;
    end else begin
      if (r_en) begin
        e = m_mem[r_adrs];
        if (BYP && w_en && (w_adrs == r_adrs)) begin
          for (int b = 0; b < NB; b++) if (w_be[b]) e[8*b +: 8] = data_in[8*b +: 8];
        end
        exp_q1.push_back(e); due_q1.push_back(cyc);
        exp_q2.push_back(e); due_q2.push_back(cyc + 1);
      end
      if (w_en) begin
        for (int b = 0; b < NB; b++) if (w_be[b]) m_mem[w_adrs][8*b +: 8] = data_in[8*b +: 8];
      end
    end
  end

  // monitor
  logic [DW-1:0] last1 = '0, last2 = '0;
  int            seen_gen = 0;

  always @(negedge clk) begin
    if (started) begin
      if (seen_gen != rst_gen) begin
        seen_gen = rst_gen;
        exp_q1.delete(); due_q1.delete();
        exp_q2.delete(); due_q2.delete();
        last1 = '0; last2 = '0;
      end
      checks++;
      if (busy1 !== !m_ready || busy2 !== !m_ready || dbg1 !== m_ready || dbg2 !== m_ready) begin
        errors++;
        $display("FAIL busy cyc=%0d: busy1=%0b busy2=%0b ready1=%0b ready2=%0b expected busy=%0b",
                 cyc, busy1, busy2, dbg1, dbg2, !m_ready);
      end
      checks++;
      if (due_q1.size() > 0 && due_q1[0] == cyc) begin
        if (rv1 !== 1'b1 || dout1 !== exp_q1[0]) begin
          errors++;
          $display("FAIL lat1_read cyc=%0d: r_valid=%0b data_out=%h expected r_valid=1 data_out=%h",
                   cyc, rv1, dout1, exp_q1[0]);
        end
        last1 = exp_q1[0]; got1 = dout1;
        void'(exp_q1.pop_front()); void'(due_q1.pop_front());
      end else if (rv1 !== 1'b0 || dout1 !== last1) begin
        errors++;
        $display("FAIL lat1_idle cyc=%0d: r_valid=%0b data_out=%h expected r_valid=0 data_out=%h",
                 cyc, rv1, dout1, last1);
      end
      checks++;
      if (due_q2.size() > 0 && due_q2[0] == cyc) begin
        if (rv2 !== 1'b1 || dout2 !== exp_q2[0]) begin
          errors++;
          $display("FAIL lat2_read cyc=%0d: r_valid=%0b data_out=%h expected r_valid=1 data_out=%h",
                   cyc, rv2, dout2, exp_q2[0]);
        end
        last2 = exp_q2[0]; got2 = dout2;
        void'(exp_q2.pop_front()); void'(due_q2.pop_front());
      end else if (rv2 !== 1'b0 || dout2 !== last2) begin
        errors++;
        $display("FAIL lat2_idle cyc=%0d: r_valid=%0b data_out=%h expected r_valid=0 data_out=%h",
                 cyc, rv2, dout2, last2);
      end
    end
  end

  // driver tasks
  task automatic check32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    w_en = 1'b0; r_en = 1'b0; w_be = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    w_en = 1'b1; w_adrs = a; data_in = d; w_be = be;
    @(negedge clk);
    w_en = 1'b0; w_be = '0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    r_en = 1'b1; r_adrs = a;
    @(negedge clk);
    r_en = 1'b0;
  endtask

  // cycles spent busy, counting the deassertion cycle; bounded
  task automatic count_busy(output int n);
    n = 0;
    while (busy1 === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int            n;
    logic [6:0]    pat;
    logic [DW-1:0] dat [7];
    reset = 1'b1; idle(); w_adrs = '0; r_adrs = '0; data_in = '0;
    step(3);

    // clear after reset, with a write and read pending that must be ignored
    reset = 1'b0;
    w_en = 1'b1; w_adrs = 4'd3; data_in = 32'hDEADBEEF; w_be = 4'hF;
    r_en = 1'b1; r_adrs = 4'd3;
    count_busy(n);
    idle();
    check32("busy_len_after_reset", DW'(n), 32'd16);
    for (int a = 0; a < DEPTH; a++) do_read(AW'(a));
    do_read(4'd3);
    step(3);
    check32("addr3_busy_write_ignored_lat1", got1, 32'h0);
    check32("addr3_busy_write_ignored_lat2", got2, 32'h0);

    // byte enables
    do_write(4'd5, 32'h11223344, 4'b1111);
    do_write(4'd5, 32'hAABBCCDD, 4'b0101);
    do_read(4'd5);
    step(3);
    check32("byte_merge_lat1", got1, 32'h11BB33DD);
    check32("byte_merge_lat2", got2, 32'h11BB33DD);

    // same-address read during write
    w_en = 1'b1; w_adrs = 4'd7; data_in = 32'hCAFEF00D; w_be = 4'hF;
    r_en = 1'b1; r_adrs = 4'd7;
    @(negedge clk);
    idle();
    step(3);
    check32("rdw_same_addr", got2, BYP ? 32'hCAFEF00D : 32'h0);
    do_read(4'd7);
    step(3);
    check32("rdw_followup", got2, 32'hCAFEF00D);

    // back-to-back reads on the RD_LAT=2 bank
    for (int i = 0; i < 4; i++) do_write(AW'(i), 32'hA0 + DW'(i), 4'hF);
    for (int i = 0; i < 7; i++) begin
      r_en = (i < 4); r_adrs = AW'(i);
      @(negedge clk);
      pat[i] = rv2; dat[i] = dout2;
    end
    idle();
    check32("lat2_valid_pattern", DW'(pat), 32'b0011110);
    for (int i = 0; i < 4; i++) check32("lat2_burst_data", dat[i+1], 32'hA0 + DW'(i));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      w_en = 1'($urandom_range(0, 1)); w_adrs = AW'($urandom_range(0, DEPTH-1));
      w_be = NB'($urandom_range(0, 15)); data_in = $urandom;
      r_en = 1'($urandom_range(0, 1));
      r_adrs = ($urandom_range(0, 3) == 0) ? w_adrs : AW'($urandom_range(0, DEPTH-1));
      @(negedge clk);
    end
    idle();
    step(3);

    // reset in the middle of the clear pass
    reset = 1'b1; step(1); reset = 1'b0;
    step(8);
    reset = 1'b1; step(1); reset = 1'b0;
    count_busy(n);
    check32("busy_len_after_midclear_reset", DW'(n), 32'd16);
    step(2);

    // reset with a read in flight
    do_write(4'd9, 32'h5A5A1234, 4'hF);
    r_en = 1'b1; r_adrs = 4'd9;
    @(negedge clk);
    r_en = 1'b0; reset = 1'b1;
    @(negedge clk);
    check32("inflight_rvalid_dropped", DW'(rv2), 32'h0);
    check32("inflight_data_out_zero", dout2, 32'h0);
    step(2);
    reset = 1'b0;
    count_busy(n);
    check32("busy_len_after_inflight_reset", DW'(n), 32'd16);
    do_read(4'd9);
    step(3);
    check32("addr9_cleared", got2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
